edge_update_sched: RTL and testbench
====================================

// Module: edge_update_sched
// PURPOSE
//  Queues edge-weight updates (src, dst, weight) written by the host over the Avalon slave.
//  Sequences the Bellman-Ford container one update at a time: load operands, pulse its reset,
//  pulse its start, then wait for done. Sits between the bus interface and the container,
//  so host writes never stall and never corrupt a relaxation pass in progress.
// PARAMETERS
//  VTX_W      4     bits per vertex index (src/dst)
//  WEIGHT_W   32    edge weight width; equals writedata width
//  DEPTH      8     update FIFO entries (power of 2)
//  TIMEOUT    4096  max cycles in WAIT before the update is abandoned
// PORTS
//  clk        in   1         clock
//  reset      in   1         synchronous, active-high
//  chipselect in   1         Avalon select
//  write      in   1         Avalon write strobe
//  read       in   1         Avalon read strobe
//  address    in   3         Avalon word address
//  writedata  in   WEIGHT_W  Avalon write data
//  readdata   out  32        Avalon read data, registered
//  bf_src     out  VTX_W     operand: edge source, held from LOAD until the next LOAD
//  bf_dst     out  VTX_W     operand: edge destination
//  bf_weight  out  WEIGHT_W  operand: new edge weight
//  bf_reset   out  1         one-cycle container reset pulse
//  bf_start   out  1         one-cycle container start pulse
//  bf_done    in   1         container finished (level or pulse; sampled only in WAIT)
//  busy       out  1         1 whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FIFO emptied; staging regs, flags and counter cleared; state IDLE.
//   Applies mid-update as well; a pending bf_done is ignored.
//  Bus writes (chipselect&write):
//   addr0: stage src=writedata[2*VTX_W-1:VTX_W], dst=writedata[VTX_W-1:0].
//   addr1: push {staged src, staged dst, writedata} into the FIFO.
//    Staging is kept, so repeated addr1 writes reuse the same edge.
//   addr2: bit0=1 clears overflow; bit1=1 clears timeout; bit2=1 flushes the FIFO.
//    Flush does not abort an update already loaded.
//   Other addresses: ignored.
//  Full: an addr1 push when count==DEPTH and no pop that cycle is dropped; sets sticky overflow.
//   Push and pop in the same cycle: both happen; count unchanged.
//   A push to a full FIFO with a simultaneous pop is accepted.
//  Bus reads (chipselect&read): readdata valid the cycle after read, otherwise holds.
//   addr0: {count[7:0] in bits 15:8, timeout bit4, overflow bit3, busy bit2, full bit1, empty bit0}.
//   addr1: completed-update counter, 32 bit, wraps.
//   Other addresses: 0.
//  FSM states:
//   IDLE:  if !empty, pop head into bf_src/bf_dst/bf_weight -> RST. Otherwise stay.
//   RST:   bf_reset=1 for this cycle only -> START.
//   START: bf_start=1 for this cycle only; clear wait counter -> WAIT.
//   WAIT:  bf_done=1 -> completed+=1, -> IDLE.
//          Wait counter reaches TIMEOUT-1 with no done -> set sticky timeout, -> IDLE (no count).
//  Latency: write to addr1 at edge N with FIFO empty and IDLE -> operands valid after N+1;
//   bf_reset high during cycle N+1 -> N+2; bf_start high during cycle N+2 -> N+3.
//  bf_done outside WAIT is ignored. Back-to-back updates need no idle gap beyond one IDLE cycle.
//  count width is $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
// TESTING
//  T1 write a0=0x0012, a1=0xFFFFFFF6 -> bf_src=1, bf_dst=2, bf_weight=-10; bf_reset 1 cycle,
//     then bf_start 1 cycle; done after 5 cycles -> completed=1, busy=0.
//  T2 hold done low, push 10 updates with DEPTH=8 -> 1 in flight + 8 queued, 1 dropped;
//     overflow=1; then pulse done 9 times -> completed=9, updates issued in FIFO order.
//  T3 never assert done, TIMEOUT=16 -> after 16 WAIT cycles timeout=1, state IDLE, completed
//     unchanged; write a2=0x2 -> timeout=0.
//  T4 push to full FIFO in the same cycle done pops -> no overflow, count stays 8.
//  T5 assert reset while in WAIT with 3 queued -> next cycle busy=0, empty=1, all outputs 0;
//     a late bf_done is ignored.
//  T6 bf_done pulsed while IDLE -> no counter change; flush (a2=0x4) with 4 queued -> empty=1.

Source files
------------

// File: rtl/edge_update_sched.sv
// Edge-update scheduler: buffers host (src, dst, weight) updates in a FIFO and feeds
// them one at a time to the Bellman-Ford container with a reset/start/done handshake.
module edge_update_sched #(
  parameter int VTX_W    = 4,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [WEIGHT_W-1:0] writedata,
  output logic [31:0]         readdata,
  output logic [VTX_W-1:0]    bf_src,
  output logic [VTX_W-1:0]    bf_dst,
  output logic [WEIGHT_W-1:0] bf_weight,
  output logic                bf_reset,
  output logic                bf_start,
  input  logic                bf_done,
  output logic                busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WAIT_W  = $clog2(TIMEOUT);
  localparam int ENTRY_W = 2 * VTX_W + WEIGHT_W;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RST   = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]         state;
  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [VTX_W-1:0]   stage_src;
  logic [VTX_W-1:0]   stage_dst;
  logic               overflow;
  logic               timeout_flag;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [31:0]        completed;

  logic bus_wr, bus_rd, empty, full, pop, push_req, push, flush;

  assign bus_wr   = chipselect & write;
  assign bus_rd   = chipselect & read;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop      = (state == S_IDLE) && !empty;
  assign push_req = bus_wr && (address == 3'd1);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign flush    = bus_wr && (address == 3'd2) && writedata[2];

  assign bf_reset = (state == S_RST);
  assign bf_start = (state == S_START);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push && !flush)
      fifo_mem[wr_ptr] <= {stage_src, stage_dst, writedata};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_src <= '0;
      stage_dst <= '0;
      overflow  <= 1'b0;
    end else begin
      if (bus_wr && (address == 3'd0)) begin
        stage_src <= writedata[2*VTX_W-1:VTX_W];
        stage_dst <= writedata[VTX_W-1:0];
      end
      if (bus_wr && (address == 3'd2) && writedata[0])
        overflow <= 1'b0;
      else if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

  // Sequencer: operands stay on the bus from LOAD until the next LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      bf_src       <= '0;
      bf_dst       <= '0;
      bf_weight    <= '0;
      wait_cnt     <= '0;
      completed    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (bus_wr && (address == 3'd2) && writedata[1])
        timeout_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            {bf_src, bf_dst, bf_weight} <= fifo_mem[rd_ptr];
            state <= S_RST;
          end
        end
        S_RST:   state <= S_START;
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bf_done) begin
            completed <= completed + 32'd1;
            state     <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_flag <= 1'b1;
            state        <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (bus_rd) begin
      case (address)
        3'd0:    readdata <= {16'b0, 8'(count), 3'b0, timeout_flag, overflow, busy, full, empty};
        3'd1:    readdata <= completed;
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_update_sched.sv
// Scoreboard bench for edge_update_sched: issued updates and bus reads are queued as
// expectations and checked by a monitor when bf_start pulses or readdata becomes valid.
module tb_edge_update_sched;

  localparam int VTX_W    = 4;
  localparam int WEIGHT_W = 32;
  localparam int DEPTH    = 8;
  localparam int TIMEOUT  = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                chipselect;
  logic                write;
  logic                read;
  logic [2:0]          address;
  logic [WEIGHT_W-1:0] writedata;
  logic [31:0]         readdata;
  logic [VTX_W-1:0]    bf_src;
  logic [VTX_W-1:0]    bf_dst;
  logic [WEIGHT_W-1:0] bf_weight;
  logic                bf_reset;
  logic                bf_start;
  logic                bf_done;
  logic                busy;

  int tests = 0;
  int fails = 0;

  logic [39:0] exp_upd [$];
  logic [31:0] exp_rd [$];
  logic        rd_seen = 1'b0;
  logic [3:0]  stg_src = '0;
  logic [3:0]  stg_dst = '0;

  edge_update_sched #(
    .VTX_W(VTX_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .bf_src(bf_src), .bf_dst(bf_dst), .bf_weight(bf_weight),
    .bf_reset(bf_reset), .bf_start(bf_start), .bf_done(bf_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus write: inputs change on the falling edge, captured on the next rising edge.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic stageEdge(input logic [3:0] s, input logic [3:0] d);
    stg_src = s; stg_dst = d;
    applyStimulus(3'd0, {24'b0, s, d});
  endtask

  task automatic pushUpdate(input logic [31:0] w, input bit issued);
    if (issued) exp_upd.push_back({stg_src, stg_dst, w});
    applyStimulus(3'd1, w);
  endtask

  task automatic busRead(input logic [2:0] a, input logic [31:0] exp);
    exp_rd.push_back(exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic waitForWait();
    int n = 0;
    while (!(busy && !bf_reset && !bf_start) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_wait", 64'(n < 40), 64'(1));
  endtask

  task automatic completeOne();
    waitForWait();
    bf_done = 1'b1;
    @(negedge clk);
    bf_done = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1; bf_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) rd_seen <= chipselect & read;

  // Monitor: pops an expectation whenever the DUT presents an update or read data.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected_read: got 0x%0h, expected no read", readdata);
      end else begin
        checkOutput("readdata", 64'(readdata), 64'(exp_rd.pop_front()));
      end
    end
    if (bf_start) begin
      if (exp_upd.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected_start: got src=%0d dst=%0d w=0x%0h, expected none",
                 bf_src, bf_dst, bf_weight);
      end else begin
        checkOutput("issued_update", 64'({bf_src, bf_dst, bf_weight}), 64'(exp_upd.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; bf_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_pulses", 64'({bf_reset, bf_start}), 64'(0));
    checkOutput("reset_operands", 64'({bf_src, bf_dst, bf_weight}), 64'(0));
    checkOutput("reset_readdata", 64'(readdata), 64'(0));
    busRead(3'd0, 32'h1);
    busRead(3'd5, 32'h0);

    // T1: single update, handshake latency and completion
    stageEdge(4'd1, 4'd2);
    pushUpdate(32'hFFFF_FFF6, 1'b1);
    checkOutput("t1_idle_after_push", 64'(busy), 64'(0));
    @(negedge clk);
    checkOutput("t1_rst_pulse", 64'({bf_reset, bf_start, busy}), 64'(3'b101));
    checkOutput("t1_operands", 64'({bf_src, bf_dst, bf_weight}), 64'({4'd1, 4'd2, 32'hFFFF_FFF6}));
    @(negedge clk);
    checkOutput("t1_start_pulse", 64'({bf_reset, bf_start, busy}), 64'(3'b011));
    @(negedge clk);
    checkOutput("t1_wait", 64'({bf_reset, bf_start, busy}), 64'(3'b001));
    repeat (4) @(negedge clk);
    bf_done = 1'b1;
    @(negedge clk);
    bf_done = 1'b0;
    checkOutput("t1_done_idle", 64'(busy), 64'(0));
    busRead(3'd1, 32'd1);
    busRead(3'd0, 32'h1);

    // T2: overflow with 1 in flight + 8 queued, then drain in order
    doReset();
    stageEdge(4'd3, 4'd4);
    for (int i = 0; i < 10; i++) pushUpdate(32'd100 + 32'(i), i < 9);
    busRead(3'd0, 32'h80E);
    for (int i = 0; i < 9; i++) completeOne();
    busRead(3'd1, 32'd9);
    busRead(3'd0, 32'h9);
    applyStimulus(3'd2, 32'h1);
    busRead(3'd0, 32'h1);

    // T3: timeout after TIMEOUT cycles in WAIT
    doReset();
    stageEdge(4'd5, 4'd6);
    pushUpdate(32'd7, 1'b1);
    repeat (18) @(negedge clk);
    checkOutput("t3_last_wait_cycle", 64'(busy), 64'(1));
    @(negedge clk);
    checkOutput("t3_timeout_idle", 64'(busy), 64'(0));
    busRead(3'd0, 32'h11);
    busRead(3'd1, 32'd0);
    applyStimulus(3'd2, 32'h2);
    busRead(3'd0, 32'h1);

    // T4: push to a full FIFO in the cycle the head is popped
    doReset();
    stageEdge(4'd7, 4'd8);
    for (int i = 0; i < 9; i++) pushUpdate(32'd200 + 32'(i), 1'b1);
    waitForWait();
    bf_done = 1'b1;
    @(negedge clk);
    bf_done = 1'b0;
    pushUpdate(32'd300, 1'b1);
    busRead(3'd0, 32'h806);
    for (int i = 0; i < 9; i++) completeOne();
    busRead(3'd1, 32'd10);
    busRead(3'd0, 32'h1);

    // T5: reset during WAIT with three queued, late done ignored
    doReset();
    stageEdge(4'd9, 4'd10);
    pushUpdate(32'd400, 1'b1);
    for (int i = 0; i < 3; i++) pushUpdate(32'd401 + 32'(i), 1'b0);
    waitForWait();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bf_done = 1'b1;
    checkOutput("t5_busy", 64'(busy), 64'(0));
    checkOutput("t5_outputs", 64'({bf_reset, bf_start, bf_src, bf_dst, bf_weight}), 64'(0));
    checkOutput("t5_readdata", 64'(readdata), 64'(0));
    @(negedge clk);
    bf_done = 1'b0;
    checkOutput("t5_late_done", 64'(busy), 64'(0));
    busRead(3'd0, 32'h1);
    busRead(3'd1, 32'd0);

    // T6: done while IDLE is ignored; flush with four queued
    bf_done = 1'b1;
    @(negedge clk);
    bf_done = 1'b0;
    busRead(3'd1, 32'd0);
    stageEdge(4'd11, 4'd12);
    pushUpdate(32'd500, 1'b1);
    for (int i = 0; i < 4; i++) pushUpdate(32'd501 + 32'(i), 1'b0);
    busRead(3'd0, 32'h404);
    applyStimulus(3'd2, 32'h4);
    busRead(3'd0, 32'h5);
    completeOne();
    repeat (3) @(negedge clk);
    busRead(3'd0, 32'h1);
    busRead(3'd1, 32'd1);

    @(negedge clk);
    checkOutput("pending_updates", 64'(exp_upd.size()), 64'(0));
    checkOutput("pending_reads", 64'(exp_rd.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
